// File: rtl/switch_press_generator.sv
// Emits a burst of N switch presses on 'control', each HOLD_CYCLES high then GAP_CYCLES low.
// Requests are taken over valid/ready in IDLE only; abort cancels the burst silently.
module switch_press_generator #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  input  logic             abort,
  output logic             req_ready,
  output logic             control,
  output logic             press_pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] presses_left
);

  localparam int unsigned PhMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);
  localparam logic [PhW-1:0] HoldLast = PhW'(HOLD_CYCLES - 1);
  localparam logic [PhW-1:0] GapLast  = PhW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPress, StGap} state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             control_q, control_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    left_d    = left_q;
    control_d = control_q;
    pulse_d   = 1'b0;
    done_d    = 1'b0;

    if (abort && state_q != StIdle) begin
      // Cancelled bursts end without a done pulse.
      state_d   = StIdle;
      phase_d   = '0;
      left_d    = '0;
      control_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_count != '0) begin
              state_d   = StPress;
              phase_d   = '0;
              left_d    = req_count;
              control_d = 1'b1;
              pulse_d   = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StPress: begin
          if (phase_q == HoldLast) begin
            state_d   = StGap;
            phase_d   = '0;
            control_d = 1'b0;
            left_d    = left_q - CNT_W'(1);
          end else begin
            phase_d = phase_q + PhW'(1);
          end
        end
        StGap: begin
          if (phase_q == GapLast) begin
            phase_d = '0;
            if (left_q != '0) begin
              state_d   = StPress;
              control_d = 1'b1;
              pulse_d   = 1'b1;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            phase_d = phase_q + PhW'(1);
          end
        end
        default: begin
          state_d   = StIdle;
          phase_d   = '0;
          left_d    = '0;
          control_d = 1'b0;
        end
      endcase
    end

    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      left_q    <= '0;
      control_q <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      left_q    <= left_d;
      control_q <= control_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign req_ready    = ready_q;
  assign control      = control_q;
  assign press_pulse  = pulse_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign presses_left = left_q;

endmodule

// File: tb/tb_switch_press_generator.sv
// Bench for switch_press_generator: cycle-accurate comparison against an arithmetic
// model of the burst timeline, with directed and randomized bursts.
module tb_switch_press_generator;

  localparam int unsigned H = 4;
  localparam int unsigned G = 4;
  localparam int unsigned W = 4;
  localparam int L = H + G;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_count = '0;
  logic         abort = 1'b0;
  logic         req_ready, control, press_pulse, busy, done;
  logic [W-1:0] presses_left;
  logic [W+4:0] obs;

  int checks = 0;
  int failures = 0;

  switch_press_generator #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .CNT_W      (W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_count   (req_count),
    .abort       (abort),
    .req_ready   (req_ready),
    .control     (control),
    .press_pulse (press_pulse),
    .busy        (busy),
    .done        (done),
    .presses_left(presses_left)
  );

  always #5 clock = ~clock;

  assign obs = {req_ready, control, press_pulse, busy, done, presses_left};

  // Expected {ready, control, pulse, busy, done, left} in cycle t after accepting n
  // (t=1 is the first cycle after the accept edge). abort_t=0 means no abort.
  function automatic logic [W+4:0] model(int n, int t, int abort_t);
    logic [W+4:0] e;
    int p, o;
    e = '0;
    e[W+4] = 1'b1;
    if (abort_t != 0 && t > abort_t) return e;
    if (n > 0 && t <= n * L) begin
      p = (t - 1) / L;
      o = (t - 1) % L;
      e[W+4] = 1'b0;
      e[W+3] = (o < H);
      e[W+2] = (o == 0);
      e[W+1] = 1'b1;
      e[W-1:0] = (o < H) ? W'(n - p) : W'(n - p - 1);
    end else if ((n == 0 && t == 1) || (n > 0 && t == n * L + 1)) begin
      e[W] = 1'b1;
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [W+4:0] idle_exp;
    idle_exp = '0;
    idle_exp[W+4] = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (obs[W+3:0] !== '0) begin
      failures++;
      $display("FAIL reset_held got=%b exp=%b", obs[W+3:0], {(W+4){1'b0}});
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== idle_exp) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, idle_exp);
      end
    end
  endtask

  task automatic test_burst(input int n, input string name);
    int rises;
    logic prev;
    rises = 0;
    prev = 1'b0;
    req_valid = 1'b1;
    req_count = W'(n);
    for (int t = 1; t <= n * L + 4; t++) begin
      @(negedge clock);
      if (t == 1) req_valid = 1'b0;
      if (control && !prev) rises++;
      prev = control;
      checks++;
      if (obs !== model(n, t, 0)) begin
        failures++;
        $display("FAIL %s t=%0d got=%b exp=%b", name, t, obs, model(n, t, 0));
      end
    end
    checks++;
    if (rises != n) begin
      failures++;
      $display("FAIL %s_rises got=%0d exp=%0d", name, rises, n);
    end
  endtask

  task automatic test_ignored();
    req_valid = 1'b1;
    req_count = W'(2);
    for (int t = 1; t <= 2 * L + 3; t++) begin
      @(negedge clock);
      if (t == 1) req_valid = 1'b0;
      checks++;
      if (obs !== model(2, t, 0)) begin
        failures++;
        $display("FAIL ignored t=%0d got=%b exp=%b", t, obs, model(2, t, 0));
      end
      // Competing request held during the first press and gap.
      if (t == 2) begin
        req_valid = 1'b1;
        req_count = W'(5);
      end
      if (t == 10) req_valid = 1'b0;
    end
  endtask

  task automatic test_abort();
    int abort_t;
    abort_t = L + 2;
    req_valid = 1'b1;
    req_count = W'(4);
    for (int t = 1; t <= abort_t + 6; t++) begin
      @(negedge clock);
      if (t == 1) req_valid = 1'b0;
      if (t == abort_t + 1) abort = 1'b0;
      checks++;
      if (obs !== model(4, t, abort_t)) begin
        failures++;
        $display("FAIL abort t=%0d got=%b exp=%b", t, obs, model(4, t, abort_t));
      end
      if (t == abort_t) abort = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1;
    req_count = W'(1);
    for (int t = 1; t <= L + 1; t++) begin
      @(negedge clock);
      if (t == 1) req_valid = 1'b0;
      checks++;
      if (obs !== model(1, t, 0)) begin
        failures++;
        $display("FAIL b2b_first t=%0d got=%b exp=%b", t, obs, model(1, t, 0));
      end
    end
    // Accepted at the edge that ends the done cycle.
    req_valid = 1'b1;
    req_count = W'(2);
    for (int t = 1; t <= 2 * L + 2; t++) begin
      @(negedge clock);
      if (t == 1) req_valid = 1'b0;
      checks++;
      if (obs !== model(2, t, 0)) begin
        failures++;
        $display("FAIL b2b_second t=%0d got=%b exp=%b", t, obs, model(2, t, 0));
      end
    end
  endtask

  task automatic test_random();
    int n, abort_t, last;
    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(0, (1 << W) - 1));
      abort_t = 0;
      if (n > 0 && $urandom_range(0, 1) == 1) abort_t = int'($urandom_range(1, n * L));
      last = (n == 0) ? 3 : n * L + 3;
      req_valid = 1'b1;
      req_count = W'(n);
      for (int t = 1; t <= last; t++) begin
        @(negedge clock);
        if (t == 1) req_valid = 1'b0;
        if (t == abort_t + 1) abort = 1'b0;
        checks++;
        if (obs !== model(n, t, abort_t)) begin
          failures++;
          $display("FAIL random it=%0d n=%0d abort_t=%0d t=%0d got=%b exp=%b",
                   it, n, abort_t, t, obs, model(n, t, abort_t));
        end
        if (abort_t != 0 && t == abort_t) abort = 1'b1;
      end
      abort = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [W+4:0] idle_exp;
    idle_exp = '0;
    idle_exp[W+4] = 1'b1;
    req_valid = 1'b1;
    req_count = W'(3);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (control !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre got=%b exp=1", control);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs[W+3:0] !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=%b", obs[W+3:0], {(W+4){1'b0}});
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== idle_exp) begin
      failures++;
      $display("FAIL reset_mid_after got=%b exp=%b", obs, idle_exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_burst(1, "single");
    test_burst(3, "triple");
    test_burst(0, "zero");
    test_ignored();
    test_abort();
    test_back_to_back();
    test_burst((1 << W) - 1, "max");
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
